// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline-stage register with a one-entry skid buffer and perf counters.
// Latency: 1 cycle from acceptance into an empty stage to presentation on out_*.
// Backpressure: in_ready is a flop (skid empty), so out_ready never reaches in_ready combinationally.
module pipe_stage_reg #(
  parameter int DATA_W = 111,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              clr_cnt,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Main entry: drives the outputs directly.
  logic              m_v_q, m_v_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;

  // Skid entry: absorbs the one beat already in flight when the downstream stalls.
  logic              s_v_q, s_v_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

  logic [CNT_W-1:0]  bubble_q, bubble_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic acc;
  logic fire;

  // Handshake events; in_ready is the registered "skid empty" flag.
  assign in_ready = ~s_v_q;
  assign acc      = in_valid & ~s_v_q;
  assign fire     = m_v_q & out_ready;

  assign out_valid  = m_v_q;
  assign out_data   = m_data_q;
  assign out_ctrl   = m_ctrl_q;
  assign bubble_cnt = bubble_q;
  assign stall_cnt  = stall_q;

  // Entry next-state: flush kills both entries (control zeroed, data held),
  // otherwise refill M from S or the input, or park the input in S while stalled.
  always_comb begin
    m_v_d    = m_v_q;
    m_data_d = m_data_q;
    m_ctrl_d = m_ctrl_q;
    s_v_d    = s_v_q;
    s_data_d = s_data_q;
    s_ctrl_d = s_ctrl_q;

    if (flush) begin
      m_v_d    = 1'b0;
      s_v_d    = 1'b0;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else if (!m_v_q || fire) begin
      if (s_v_q) begin
        // Skid drains into main first to keep FIFO order.
        m_v_d    = 1'b1;
        m_data_d = s_data_q;
        m_ctrl_d = s_ctrl_q;
        s_v_d    = 1'b0;
        if (acc) begin
          s_v_d    = 1'b1;
          s_data_d = in_data;
          s_ctrl_d = in_ctrl;
        end
      end else if (acc) begin
        m_v_d    = 1'b1;
        m_data_d = in_data;
        m_ctrl_d = in_ctrl;
      end else begin
        // Bubble: control bits zeroed so downstream sees no side effects.
        m_v_d    = 1'b0;
        m_ctrl_d = '0;
      end
    end else if (acc) begin
      s_v_d    = 1'b1;
      s_data_d = in_data;
      s_ctrl_d = in_ctrl;
    end
  end

  // Counter next-state: clear wins over increment, both saturate at all-ones.
  always_comb begin
    bubble_d = bubble_q;
    stall_d  = stall_q;
    if (clr_cnt) begin
      bubble_d = '0;
      stall_d  = '0;
    end else begin
      if (!m_v_q && (bubble_q != CNT_MAX)) begin
        bubble_d = bubble_q + 1'b1;
      end
      if (m_v_q && !out_ready && (stall_q != CNT_MAX)) begin
        stall_d = stall_q + 1'b1;
      end
    end
  end

  // State register with synchronous reset clearing entries, payloads and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_v_q    <= 1'b0;
      m_data_q <= '0;
      m_ctrl_q <= '0;
      s_v_q    <= 1'b0;
      s_data_q <= '0;
      s_ctrl_q <= '0;
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      m_v_q    <= m_v_d;
      m_data_q <= m_data_d;
      m_ctrl_q <= m_ctrl_d;
      s_v_q    <= s_v_d;
      s_data_q <= s_data_d;
      s_ctrl_q <= s_ctrl_d;
      bubble_q <= bubble_d;
      stall_q  <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios plus random traffic against a queue model.
// A second instance with 4-bit counters shares all inputs to exercise saturation.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_pipe_stage_reg;
  localparam int DATA_W = 111;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 16;
  localparam int E_W    = DATA_W + CTRL_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, clr_cnt, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  bubble_cnt, stall_cnt;

  logic              s_in_ready, s_out_valid;
  logic [DATA_W-1:0] s_out_data;
  logic [CTRL_W-1:0] s_out_ctrl;
  logic [3:0]        s_bubble_cnt, s_stall_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .bubble_cnt(bubble_cnt), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush), .clr_cnt(clr_cnt),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .bubble_cnt(s_bubble_cnt), .stall_cnt(s_stall_cnt)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity two; in_ready means fewer than two held.
  logic [E_W-1:0]    q[$];
  logic [DATA_W-1:0] last_d;
  logic [15:0]       m_bub, m_stl;
  logic [3:0]        m_bub4, m_stl4;

  function automatic void model_step();
    bit empty, acc, fire;
    if (rst) begin
      q.delete();
      last_d = '0;
      m_bub = '0; m_stl = '0; m_bub4 = '0; m_stl4 = '0;
      return;
    end
    empty = (q.size() == 0);
    if (clr_cnt) begin
      m_bub = '0; m_stl = '0; m_bub4 = '0; m_stl4 = '0;
    end else begin
      if (empty) begin
        if (m_bub  != 16'hFFFF) m_bub  = m_bub + 16'd1;
        if (m_bub4 != 4'hF)     m_bub4 = m_bub4 + 4'd1;
      end
      if (!empty && !out_ready) begin
        if (m_stl  != 16'hFFFF) m_stl  = m_stl + 16'd1;
        if (m_stl4 != 4'hF)     m_stl4 = m_stl4 + 4'd1;
      end
    end
    acc  = in_valid && (q.size() < 2);
    fire = !empty && out_ready;
    if (!empty) last_d = q[0][E_W-1:CTRL_W];
    if (flush) begin
      q.delete();
    end else begin
      if (fire) void'(q.pop_front());
      if (acc)  q.push_back({in_data, in_ctrl});
    end
  endfunction

  task automatic compare_all();
    logic [E_W-1:0]    head;
    logic [DATA_W-1:0] exp_d;
    logic [CTRL_W-1:0] exp_c;
    bit                ev;
    ev    = (q.size() > 0);
    head  = ev ? q[0] : '0;
    exp_d = ev ? head[E_W-1:CTRL_W] : last_d;
    exp_c = ev ? head[CTRL_W-1:0] : '0;
    chk("out_valid",  128'(out_valid),  128'(ev));
    chk("in_ready",   128'(in_ready),   128'(q.size() < 2));
    chk("out_data",   128'(out_data),   128'(exp_d));
    chk("out_ctrl",   128'(out_ctrl),   128'(exp_c));
    chk("bubble_cnt", 128'(bubble_cnt), 128'(m_bub));
    chk("stall_cnt",  128'(stall_cnt),  128'(m_stl));
    chk("sat_bubble", 128'(s_bubble_cnt), 128'(m_bub4));
    chk("sat_stall",  128'(s_stall_cnt),  128'(m_stl4));
    chk("sat_out_data", 128'(s_out_data), 128'(exp_d));
  endtask

  task automatic tick(input logic r, input logic f, input logic c, input logic iv,
                      input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] ct,
                      input logic ordy);
    rst = r; flush = f; clr_cnt = c; in_valid = iv;
    in_data = d; in_ctrl = ct; out_ready = ordy;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, ordy);
  endtask

  task automatic push(input int v, input logic ordy);
    tick(1'b0, 1'b0, 1'b0, 1'b1, DATA_W'(v), CTRL_W'(v * 3 + 1), ordy);
  endtask

  logic [127:0] r128;

  initial begin
    int nxt;
    rst = 1'b1; flush = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0;
    in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    q.delete(); last_d = '0;
    m_bub = '0; m_stl = '0; m_bub4 = '0; m_stl4 = '0;
    @(negedge clk);

    // Reset values
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(1));
    chk("rst_bubble",    128'(bubble_cnt), 128'(0));

    // Idle bubbles then counter clear
    for (int i = 0; i < 3; i++) idle(1'b1);
    chk("idle_bubble3", 128'(bubble_cnt), 128'(3));
    tick(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
    chk("clr_bubble", 128'(bubble_cnt), 128'(0));

    // Streaming 1..10 at full rate
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      push(i, 1'b1);
      chk("stream_data", 128'(out_data), 128'(i));
    end
    idle(1'b1);
    chk("stream_stall", 128'(stall_cnt), 128'(0));

    // Backpressure: out_ready low for cycles 3..6 while streaming 1..6
    tick(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 1'b1);
    nxt = 1;
    for (int k = 1; k <= 14; k++) begin
      logic rdy_pre, ordy;
      rdy_pre = in_ready;
      ordy = !(k >= 3 && k <= 6);
      if (nxt <= 6) push(nxt, ordy);
      else idle(ordy);
      if (nxt <= 6 && rdy_pre) nxt++;
    end
    chk("bp_stall4", 128'(stall_cnt), 128'(4));

    // Flush with M=5, S=6 held and 7 offered
    push(5, 1'b0);
    push(6, 1'b0);
    chk("pre_flush_full", 128'(in_ready), 128'(0));
    tick(1'b0, 1'b1, 1'b0, 1'b1, DATA_W'(7), CTRL_W'(22), 1'b0);
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ctrl",  128'(out_ctrl),  128'(0));
    chk("flush_ready", 128'(in_ready),  128'(1));
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Flush with simultaneous fire
    push(8, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("flush_fire_valid", 128'(out_valid), 128'(0));

    // Saturation of the 4-bit counters, then reset mid-stall
    tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("sat_bubble15", 128'(s_bubble_cnt), 128'(15));
    chk("wide_bubble20", 128'(bubble_cnt), 128'(20));
    push(9, 1'b0);
    push(10, 1'b0);
    push(11, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b1, DATA_W'(12), CTRL_W'(5), 1'b0);
    chk("rst_mid_valid", 128'(out_valid), 128'(0));
    chk("rst_mid_data",  128'(out_data),  128'(0));
    chk("rst_mid_ready", 128'(in_ready),  128'(1));
    chk("rst_mid_stall", 128'(stall_cnt), 128'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [DATA_W-1:0] d;
      logic [CTRL_W-1:0] ct;
      r128 = {$urandom(), $urandom(), $urandom(), $urandom()};
      d  = r128[DATA_W-1:0];
      ct = CTRL_W'($urandom());
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 9) < 7,
           d, ct,
           $urandom_range(0, 9) < 6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
